// File: rtl/rmrv_pkg.sv
// Shared definitions for the ID/EX operand stage.
// Holds the datapath widths, the ALU function codes and the packed
// entry type used for the ID/EX register.
package rmrv_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;
    localparam int F_W  = 5;

    localparam logic [F_W-1:0] ALU_ADD = 5'b00000;
    localparam logic [F_W-1:0] ALU_SUB = 5'b00001;

    // One decoded instruction as held by the ID/EX stage.
    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            a_pc;
        logic            b_imm;
        logic [F_W-1:0]  f;
        logic [RA_W-1:0] rd;
        logic            rd_we;
        logic            is_load;
    } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Forwarding selector for one source operand.
// Picks EX/MEM data, then MEM/WB data, then the stored register value.
// x0 never matches.
//
// Ports:
//   i_rs, i_rs_data        source register address and stored value
//   i_exm_*                EX/MEM forwarding source
//   i_mwb_*                MEM/WB forwarding source
//   o_fwd                  selected operand value
//   o_exm_hit              EX/MEM targets this source (load or not)
//   o_upd                  o_fwd is safe to write back into the held entry
module fwd_mux #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] i_rs,
    input  logic [XLEN-1:0] i_rs_data,
    input  logic            i_exm_rd_we,
    input  logic [RA_W-1:0] i_exm_rd,
    input  logic [XLEN-1:0] i_exm_data,
    input  logic            i_exm_is_load,
    input  logic            i_mwb_rd_we,
    input  logic [RA_W-1:0] i_mwb_rd,
    input  logic [XLEN-1:0] i_mwb_data,
    output logic [XLEN-1:0] o_fwd,
    output logic            o_exm_hit,
    output logic            o_upd
);

    logic w_rs_nz;
    logic w_mwb_hit;

    assign w_rs_nz   = (i_rs != '0);
    assign o_exm_hit = i_exm_rd_we & (i_exm_rd == i_rs) & w_rs_nz;
    assign w_mwb_hit = i_mwb_rd_we & (i_mwb_rd == i_rs) & w_rs_nz;

    always_comb begin
        o_fwd = i_rs_data;
        if (o_exm_hit) begin
            o_fwd = i_exm_data;
        end else if (w_mwb_hit) begin
            o_fwd = i_mwb_data;
        end
    end

    // An EX/MEM load match shadows any MEM/WB match, and load data is not
    // yet valid, so nothing may be retained in that case.
    assign o_upd = o_exm_hit ? ~i_exm_is_load : w_mwb_hit;

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline stage directly upstream of the ALU.
// Holds one decoded instruction, forwards from EX/MEM and MEM/WB,
// interlocks on load-use, and drives ALU operands combinationally.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   in_valid/in_ready                handshake with decode
//   in_*                             decoded instruction fields
//   flush                            kill held and incoming instruction
//   exm_*, mwb_*                     forwarding sources
//   out_valid/out_ready              handshake with EX/MEM register
//   alu_a, alu_b, alu_f              ALU inputs
//   out_rd, out_rd_we, out_is_load   destination info passed downstream
module alu_operand_stage
    import rmrv_pkg::*;
#(
    parameter int XLEN = rmrv_pkg::XLEN,
    parameter int RA_W = rmrv_pkg::RA_W,
    parameter int F_W  = rmrv_pkg::F_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RA_W-1:0] in_rs1,
    input  logic [RA_W-1:0] in_rs2,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_a_pc,
    input  logic            in_b_imm,
    input  logic [F_W-1:0]  in_f,
    input  logic [RA_W-1:0] in_rd,
    input  logic            in_rd_we,
    input  logic            in_is_load,
    input  logic            flush,
    input  logic            exm_rd_we,
    input  logic [RA_W-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            exm_is_load,
    input  logic            mwb_rd_we,
    input  logic [RA_W-1:0] mwb_rd,
    input  logic [XLEN-1:0] mwb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [F_W-1:0]  alu_f,
    output logic [RA_W-1:0] out_rd,
    output logic            out_rd_we,
    output logic            out_is_load
);

    id_ex_t          r_entry;
    id_ex_t          w_new;
    logic [XLEN-1:0] w_fwd1;
    logic [XLEN-1:0] w_fwd2;
    logic            w_exm_hit1;
    logic            w_exm_hit2;
    logic            w_upd1;
    logic            w_upd2;
    logic            w_load_use;
    logic            w_out_fire;
    logic            w_capture;

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd1 (
        .i_rs          (r_entry.rs1),
        .i_rs_data     (r_entry.rs1_data),
        .i_exm_rd_we   (exm_rd_we),
        .i_exm_rd      (exm_rd),
        .i_exm_data    (exm_data),
        .i_exm_is_load (exm_is_load),
        .i_mwb_rd_we   (mwb_rd_we),
        .i_mwb_rd      (mwb_rd),
        .i_mwb_data    (mwb_data),
        .o_fwd         (w_fwd1),
        .o_exm_hit     (w_exm_hit1),
        .o_upd         (w_upd1)
    );

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd2 (
        .i_rs          (r_entry.rs2),
        .i_rs_data     (r_entry.rs2_data),
        .i_exm_rd_we   (exm_rd_we),
        .i_exm_rd      (exm_rd),
        .i_exm_data    (exm_data),
        .i_exm_is_load (exm_is_load),
        .i_mwb_rd_we   (mwb_rd_we),
        .i_mwb_rd      (mwb_rd),
        .i_mwb_data    (mwb_data),
        .o_fwd         (w_fwd2),
        .o_exm_hit     (w_exm_hit2),
        .o_upd         (w_upd2)
    );

    // Only a source the ALU actually consumes can stall on a load.
    assign w_load_use = r_entry.valid & exm_is_load &
                        ((w_exm_hit1 & ~r_entry.a_pc) | (w_exm_hit2 & ~r_entry.b_imm));

    assign out_valid  = r_entry.valid & ~w_load_use;
    assign w_out_fire = out_valid & out_ready;
    assign in_ready   = ~r_entry.valid | w_out_fire;
    assign w_capture  = in_valid & in_ready;

    assign alu_a       = r_entry.a_pc  ? r_entry.pc  : w_fwd1;
    assign alu_b       = r_entry.b_imm ? r_entry.imm : w_fwd2;
    assign alu_f       = r_entry.f;
    assign out_rd      = r_entry.rd;
    assign out_rd_we   = r_entry.rd_we;
    assign out_is_load = r_entry.is_load;

    always_comb begin
        w_new          = '0;
        w_new.valid    = 1'b1;
        w_new.rs1      = in_rs1;
        w_new.rs2      = in_rs2;
        w_new.rs1_data = in_rs1_data;
        w_new.rs2_data = in_rs2_data;
        w_new.imm      = in_imm;
        w_new.pc       = in_pc;
        w_new.a_pc     = in_a_pc;
        w_new.b_imm    = in_b_imm;
        w_new.f        = in_f;
        w_new.rd       = in_rd;
        w_new.rd_we    = in_rd_we;
        w_new.is_load  = in_is_load;
    end

    // While held, forwarded values are folded into the stored data so they
    // survive the producer leaving the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry <= '0;
        end else if (flush) begin
            r_entry.valid <= 1'b0;
        end else if (w_capture) begin
            r_entry <= w_new;
        end else if (w_out_fire) begin
            r_entry.valid <= 1'b0;
        end else if (r_entry.valid) begin
            if (w_upd1) begin
                r_entry.rs1_data <= w_fwd1;
            end
            if (w_upd2) begin
                r_entry.rs2_data <= w_fwd2;
            end
        end
    end

endmodule
